// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants for the VGA raster timing block: default 640x480@60
//   timing, derived totals and sync window bounds, the coordinate width and
//   a small window-decode helper used by the top level.
//   Optional feature macro used by the top level: VGA_TIMING_PIXEL_DOUBLE_EN.
package vga_timing_pkg;

  localparam int CW = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  // Half-open window test lo <= v < hi. One extra bit keeps a bound equal
  // to 1024 representable.
  function automatic logic in_window(input logic [CW:0] v,
                                     input logic [CW:0] lo,
                                     input logic [CW:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   Modulo-N counter for one raster axis.
//   Ports:
//     clk       in   pixel clock
//     rst       in   asynchronous active-high reset (count -> N-1)
//     inc       in   advance the count this cycle
//     count_nxt out  value the count takes on the coming edge (combinational)
//     wrap      out  registered flag, high while the count sits at N-1, so
//                    the next increment wraps to 0
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int N = H_TOTAL,
  parameter int W = CW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count_nxt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  if (N < 2 || N > (2 ** W)) begin : g_bad_modulus
    $error("vga_axis_counter: modulus %0d does not fit %0d bits", N, W);
  end

  logic [W-1:0] count;

  always_comb begin
    count_nxt = count;
    if (inc) begin
      if (count == LAST) count_nxt = '0;
      else               count_nxt = count + 1'b1;
    end
  end

  // Reset parks the count on its last value so the first edge after release
  // lands on 0, and the wrap flag agrees with that parked value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= LAST;
      wrap  <= 1'b1;
    end else begin
      count <= count_nxt;
      wrap  <= (count_nxt == LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing generator (default 640x480@60 at 25.2 MHz).
//   Ports:
//     clk          in   pixel clock
//     rst          in   asynchronous active-high reset
//     hsync        out  horizontal sync, active level HS_POL
//     vsync        out  vertical sync, active level VS_POL
//     de           out  high inside the active area
//     x, y         out  raster position, 0..H_TOTAL-1 / 0..V_TOTAL-1
//     line_start   out  one-cycle pulse at x==0
//     frame_start  out  one-cycle pulse at x==0, y==0
//   With VGA_TIMING_PIXEL_DOUBLE_EN defined, also:
//     px, py       out  x>>1, y>>1 for a 320x240 line-doubled source
//     pix_fetch    out  high on active cycles with even x
//   Every output is registered from the counters' next values, so all of
//   them describe the same pixel in the same cycle.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_PIXEL_DOUBLE_EN
  ,
  output logic [CW-2:0] px,
  output logic [CW-2:0] py,
  output logic          pix_fetch
`endif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_timing_gen: H_TOTAL=%0d V_TOTAL=%0d exceed 1024", H_TOTAL, V_TOTAL);
  end

  localparam logic [CW:0] HA_C  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] VA_C  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] HSS_C = (CW+1)'(HS_START);
  localparam logic [CW:0] HSE_C = (CW+1)'(HS_END);
  localparam logic [CW:0] VSS_C = (CW+1)'(VS_START);
  localparam logic [CW:0] VSE_C = (CW+1)'(VS_END);

  logic [CW-1:0] hc_nxt_p0;
  logic [CW-1:0] vc_nxt_p0;
  logic          h_wrap_p0;
  logic          v_wrap_p0;

  vga_axis_counter #(
    .N (H_TOTAL),
    .W (CW)
  ) u_hcnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (1'b1),
    .count_nxt (hc_nxt_p0),
    .wrap      (h_wrap_p0)
  );

  // h_wrap is high exactly while hc==H_TOTAL-1, so vc steps on the same edge
  // that hc returns to 0.
  vga_axis_counter #(
    .N (V_TOTAL),
    .W (CW)
  ) u_vcnt (
    .clk       (clk),
    .rst       (rst),
    .inc       (h_wrap_p0),
    .count_nxt (vc_nxt_p0),
    .wrap      (v_wrap_p0)
  );

  // ---- stage p0: decode the position the counters move to on this edge ----
  logic [CW:0] hx_p0;
  logic [CW:0] vy_p0;
  logic        de_p0;
  logic        hs_act_p0;
  logic        vs_act_p0;
  logic        ls_p0;
  logic        fs_p0;

  always_comb begin
    hx_p0     = {1'b0, hc_nxt_p0};
    vy_p0     = {1'b0, vc_nxt_p0};
    de_p0     = (hx_p0 < HA_C) && (vy_p0 < VA_C);
    hs_act_p0 = in_window(hx_p0, HSS_C, HSE_C);
    vs_act_p0 = in_window(vy_p0, VSS_C, VSE_C);
    // Both wrap flags high means the next position is (0,0); h_wrap alone
    // means the next position is x==0.
    ls_p0     = h_wrap_p0;
    fs_p0     = h_wrap_p0 && v_wrap_p0;
  end

  // ---- stage p1: registered outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= hc_nxt_p0;
      y           <= vc_nxt_p0;
      de          <= de_p0;
      hsync       <= hs_act_p0 ? HS_POL : ~HS_POL;
      vsync       <= vs_act_p0 ? VS_POL : ~VS_POL;
      line_start  <= ls_p0;
      frame_start <= fs_p0;
    end
  end

`ifdef VGA_TIMING_PIXEL_DOUBLE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px        <= '0;
      py        <= '0;
      pix_fetch <= 1'b0;
    end else begin
      px        <= hc_nxt_p0[CW-1:1];
      py        <= vc_nxt_p0[CW-1:1];
      pix_fetch <= de_p0 && !hc_nxt_p0[0];
    end
  end
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Consumes the 25.2 MHz pixel clock from the clock divider and generates 640x480@60 Hz VGA raster timing.
- Outputs: hsync, vsync, display-enable and active-area pixel coordinates, plus line and frame start strobes.
- Sits between the divider and the video/pixel fetch logic, which uses x/y and de to address the framebuffer and drive RGB.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)

Ports:
- clk  input  1  25.2 MHz pixel clock
- rst  input  1  asynchronous, active-high reset
- hsync  output  1  horizontal sync, polarity per HS_POL
- vsync  output  1  vertical sync, polarity per VS_POL
- de  output  1  high while position is inside the active area
- x  output  10  horizontal position 0..H_TOTAL-1
- y  output  10  vertical position 0..V_TOTAL-1
- line_start  output  1  one-cycle pulse when x==0
- frame_start  output  1  one-cycle pulse when x==0 and y==0

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024; elaboration-time check fails otherwise.
- Two internal counters, hc and vc.
  - hc increments every clk; wraps H_TOTAL-1 -> 0.
  - vc increments only when hc wraps; wraps V_TOTAL-1 -> 0 on the same edge that hc wraps.
- All outputs are registers decoded from the next counter value, so x, y, de, hsync, vsync and the strobes describe the same pixel on the same cycle. There is no internal skew between them.
- Reset state (asynchronous): hc=H_TOTAL-1, vc=V_TOTAL-1. Outputs: x=0, y=0, de=0, hsync=~HS_POL, vsync=~VS_POL, line_start=0, frame_start=0.
- First rising edge after rst deasserts: x=0, y=0, de=1, line_start=1, frame_start=1.
- Decode for position (x, y):
  - de = (x < H_ACTIVE) && (y < V_ACTIVE)
  - hsync active when H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vsync active when V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC (490..491), for the full line including blanking
  - line_start = (x==0); frame_start = (x==0 && y==0)
- Frame length: exactly H_TOTAL*V_TOTAL = 420000 cycles; frame_start period equals this exactly.
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). Timing restarts at (0,0) on the first edge after release. No partial sync pulse is stretched or preserved.
- No clock enable and no stall; the counters free-run.

Optional Feature:
- Macro: VGA_TIMING_PIXEL_DOUBLE_EN.
- When defined, adds outputs px[8:0] = x>>1 and py[8:0] = y>>1, both registered and aligned with x/y. Also adds pix_fetch (1 bit), high on active cycles with x even (x[0]==0 && de), for 320x240 line-doubled sources.
  - Reset values: px=0, py=0, pix_fetch=0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - default timing constants (H_*/V_* for 640x480@60)
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END
  - coordinate width constant CW=10
- Sub-module vga_axis_counter: a modulo-N counter with an increment input, a registered wrap output and a reset-to-(N-1) value. It is instantiated twice: horizontal with increment tied high, vertical with increment driven by the horizontal wrap.

Test Plan:
- Reset release: hold rst 5 cycles then release -> during reset hsync=vsync=1, de=0. First edge after release gives x=0, y=0, de=1, frame_start=1.
- Horizontal timing: run one line -> de high for exactly 640 cycles; hsync low for 96 cycles starting at x=656; line_start pulses every 800 cycles.
- Vertical timing: run full frame -> vsync low only on lines 490-491 (1600 cycles); de never high on y≥480; frame_start period exactly 420000 cycles.
- Wrap boundary: observe x=799, y=524 -> next cycle x=0, y=0, line_start=1, frame_start=1. Last line also checked at x=799, y=479 -> x=0, y=480, de=0.
- Mid-frame reset: assert rst at x=700, y=491 (hsync and vsync active) -> sync outputs go inactive within the same cycle. After release, timing restarts at (0,0).
- With VGA_TIMING_PIXEL_DOUBLE_EN: at x=5, y=9 -> px=2, py=4, pix_fetch=0. At x=6 -> pix_fetch=1. pix_fetch count per active line is 320.
